// File: rtl/mdu_seq_if.sv
// Core <-> mdu_seq handshake bundle: op request side, flush, and tagged result side.
// res_rem is present only when MDU_REM_EN is defined.
interface mdu_seq_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    logic             start_valid;
    logic             start_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [TAG_W-1:0] tag_in;
    logic             flush;
    logic             busy;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic [TAG_W-1:0] res_tag;
    logic             res_exc;
    logic [WIDTH-1:0] res_code;
`ifdef MDU_REM_EN
    logic [WIDTH-1:0] res_rem;
`endif

    modport master (
        output start_valid, op, operand_a, operand_b, tag_in, flush, res_ready,
        input  start_ready, busy, res_valid, res_data, res_tag, res_exc, res_code
`ifdef MDU_REM_EN
        , input res_rem
`endif
    );

    modport slave (
        input  start_valid, op, operand_a, operand_b, tag_in, flush, res_ready,
        output start_ready, busy, res_valid, res_data, res_tag, res_exc, res_code
`ifdef MDU_REM_EN
        , output res_rem
`endif
    );
endinterface

// File: rtl/mdu_seq.sv
// Sequential signed/unsigned mul/div with tag echo and exceptions; MDU_REM_EN adds res_rem.
// Latency: accept at edge k -> res_valid after edge k+WIDTH+2.
// Result held in DONE until res_ready; start_ready only in IDLE or DONE with res_ready; flush wins.
module mdu_seq #(
    parameter int WIDTH    = 32,
    parameter int TAG_W    = 5,
    parameter int EXC_MULT = 4,
    parameter int EXC_DIV  = 5
) (
    input  logic      clock,
    input  logic      reset,
    mdu_seq_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE} state_t;

    state_t             r_state;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [TAG_W-1:0]   r_tag;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div0;
    logic               r_ovf;

    logic               r_busy;
    logic               r_res_valid;
    logic [WIDTH-1:0]   r_res_data;
    logic [TAG_W-1:0]   r_res_tag;
    logic               r_res_exc;
    logic [WIDTH-1:0]   r_res_code;
`ifdef MDU_REM_EN
    logic [WIDTH-1:0]   r_res_rem;
`endif

    logic               w_start_ready;
    logic               w_accept;
    logic               w_signed;
    logic               w_is_div;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_sh;
    logic               w_div_ge;
    logic [WIDTH:0]     w_div_rem;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH:0]     w_top;
    logic               w_mul_exc;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_start_ready = ~reset & ((r_state == S_IDLE) | ((r_state == S_DONE) & bus.res_ready));
    assign w_accept      = bus.start_valid & w_start_ready;

    assign w_signed = ~r_op[1];
    assign w_is_div = r_op[0];
    assign w_a_neg  = w_signed & r_a[WIDTH-1];
    assign w_b_neg  = w_signed & r_b[WIDTH-1];
    assign w_mag_a  = w_a_neg ? -r_a : r_a;
    assign w_mag_b  = w_b_neg ? -r_b : r_b;

    // Multiply: r_acc = {partial sum, remaining multiplier bits}, r_b = multiplicand.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});

    // Divide: r_acc = {partial remainder, dividend shifting out / quotient shifting in}.
    assign w_div_sh  = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_ge  = (w_div_sh >= {1'b0, r_b});
    assign w_div_rem = w_div_ge ? (w_div_sh - {1'b0, r_b}) : w_div_sh;

    assign w_prod    = r_neg_q ? -r_acc : r_acc;
    assign w_top     = w_prod[2*WIDTH-1:WIDTH-1];
    assign w_mul_exc = w_signed ? ~((&w_top) | ~(|w_top)) : (|r_acc[2*WIDTH-1:WIDTH]);
    assign w_quo     = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem     = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_tag       <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_div0      <= 1'b0;
            r_ovf       <= 1'b0;
            r_busy      <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_tag   <= '0;
            r_res_exc   <= 1'b0;
            r_res_code  <= '0;
`ifdef MDU_REM_EN
            r_res_rem   <= '0;
`endif
        end else if (bus.flush) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op  <= bus.op;
                r_a   <= bus.operand_a;
                r_b   <= bus.operand_b;
                r_tag <= bus.tag_in;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_PREP;
                        r_busy  <= 1'b1;
                    end
                end
                S_PREP: begin
                    r_acc   <= {{WIDTH{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
                    r_b     <= w_is_div ? w_mag_b : w_mag_a;
                    r_neg_q <= w_a_neg ^ w_b_neg;
                    r_neg_r <= w_a_neg;
                    r_div0  <= (r_b == '0);
                    r_ovf   <= w_signed & (r_a == MIN_VAL) & (&r_b);
                    r_cnt   <= CNT_W'(WIDTH);
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (w_is_div)
                        r_acc <= {w_div_rem[WIDTH-1:0], r_acc[WIDTH-2:0], w_div_ge};
                    else
                        r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1))
                        r_state <= S_FIX;
                end
                S_FIX: begin
                    r_res_tag   <= r_tag;
                    r_res_valid <= 1'b1;
                    r_state     <= S_DONE;
                    if (!w_is_div) begin
                        r_res_data <= w_prod[WIDTH-1:0];
                        r_res_exc  <= w_mul_exc;
                        r_res_code <= w_mul_exc ? WIDTH'(EXC_MULT) : '0;
`ifdef MDU_REM_EN
                        r_res_rem  <= '0;
`endif
                    end else if (r_div0 || r_ovf) begin
                        r_res_data <= r_div0 ? '0 : MIN_VAL;
                        r_res_exc  <= 1'b1;
                        r_res_code <= WIDTH'(EXC_DIV);
`ifdef MDU_REM_EN
                        r_res_rem  <= '0;
`endif
                    end else begin
                        r_res_data <= w_quo;
                        r_res_exc  <= 1'b0;
                        r_res_code <= '0;
`ifdef MDU_REM_EN
                        r_res_rem  <= w_rem;
`endif
                    end
                end
                S_DONE: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= bus.start_valid ? S_PREP : S_IDLE;
                        r_busy      <= bus.start_valid;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.start_ready = w_start_ready;
    assign bus.busy        = r_busy;
    assign bus.res_valid   = r_res_valid;
    assign bus.res_data    = r_res_data;
    assign bus.res_tag     = r_res_tag;
    assign bus.res_exc     = r_res_exc;
    assign bus.res_code    = r_res_code;
`ifdef MDU_REM_EN
    assign bus.res_rem     = r_res_rem;
`else
    logic w_unused_rem;
    assign w_unused_rem = ^w_rem;
`endif
endmodule

// File: tb/tb_mdu_seq.sv
// Bench for mdu_seq at WIDTH=32: directed test-plan cases, flush/reset/back-pressure, then
// random ops against an arithmetic reference model.
module tb_mdu_seq;
    localparam int W  = 32;
    localparam int TW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mdu_seq_if #(.WIDTH(W), .TAG_W(TW)) bus ();

    mdu_seq #(.WIDTH(W), .TAG_W(TW), .EXC_MULT(4), .EXC_DIV(5)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] d;
        logic        exc;
        logic [31:0] code;
        logic [31:0] rem;
        logic [4:0]  tag;
    } exp_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] d, input logic exc, input logic [31:0] code,
                                input logic [31:0] rem, input logic [4:0] tag);
        exp_t e;
        e.d = d; e.exc = exc; e.code = code; e.rem = rem; e.tag = tag;
        return e;
    endfunction

    // Reference: plain 64-bit arithmetic; SV '/' and '%' truncate toward zero, remainder follows dividend.
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] tag);
        exp_t e;
        longint sa, sb, p;
        logic [63:0] up, pv;
        e = '0;
        e.tag = tag;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!op[0]) begin
            if (!op[1]) begin
                p = sa * sb;
                pv = p;
                e.d = pv[31:0];
                e.exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
            end else begin
                up = {32'd0, a} * {32'd0, b};
                e.d = up[31:0];
                e.exc = (up[63:32] != 32'd0);
            end
            if (e.exc) e.code = 32'd4;
        end else begin
            if (b == 32'd0) begin
                e.exc = 1'b1; e.code = 32'd5;
            end else if (!op[1] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.exc = 1'b1; e.code = 32'd5; e.d = 32'h8000_0000;
            end else if (!op[1]) begin
                p = sa / sb; pv = p; e.d = pv[31:0];
                p = sa % sb; pv = p; e.rem = pv[31:0];
            end else begin
                e.d = a / b;
                e.rem = a % b;
            end
        end
        return e;
    endfunction

    // Entered and left on a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
        int n = 0;
        while (bus.start_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("issue_ready", bus.start_ready, 1);
        bus.start_valid = 1'b1;
        bus.op = op; bus.operand_a = a; bus.operand_b = b; bus.tag_in = tag;
        @(negedge clk);
        bus.start_valid = 1'b0;
        bus.op = 2'($urandom); bus.operand_a = $urandom; bus.operand_b = $urandom;
        bus.tag_in = 5'($urandom);
    endtask

    task automatic collect(input exp_t e);
        int cyc = 1;
        while (bus.res_valid !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("res_valid", bus.res_valid, 1);
        check("latency", cyc - 1, 34);
        check("res_data", bus.res_data, e.d);
        check("res_exc", bus.res_exc, e.exc);
        check("res_code", bus.res_code, e.code);
        check("res_tag", bus.res_tag, e.tag);
        check("busy_done", bus.busy, 1);
`ifdef MDU_REM_EN
        check("res_rem", bus.res_rem, e.rem);
`endif
    endtask

    task automatic consume();
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check("valid_after_take", bus.res_valid, 0);
        check("busy_after_take", bus.busy, 0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    logic [1:0]  t_op  [10] = '{2'd0, 2'd0, 2'd2, 2'd1, 2'd1, 2'd3, 2'd1, 2'd0, 2'd0, 2'd1};
    logic [31:0] t_a   [10] = '{32'd7, 32'h0001_0000, 32'h0000_FFFF, 32'hFFFF_FFF9, 32'd5,
                                32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'd7};
    logic [31:0] t_b   [10] = '{32'hFFFF_FFFA, 32'h0001_0000, 32'h0000_FFFF, 32'd2, 32'd0,
                                32'h10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    exp_t        t_exp [10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits;
        logic [1:0] rop;
        logic [31:0] ra, rb;
        logic [4:0] rtag;

        t_exp[0] = mk(32'hFFFF_FFD6, 1'b0, 32'd0, 32'd0, 5'd9);
        t_exp[1] = mk(32'h0000_0000, 1'b1, 32'd4, 32'd0, 5'd1);
        t_exp[2] = mk(32'hFFFE_0001, 1'b0, 32'd0, 32'd0, 5'd2);
        t_exp[3] = mk(32'hFFFF_FFFD, 1'b0, 32'd0, 32'hFFFF_FFFF, 5'd3);
        t_exp[4] = mk(32'h0000_0000, 1'b1, 32'd5, 32'd0, 5'd4);
        t_exp[5] = mk(32'h0FFF_FFFF, 1'b0, 32'd0, 32'hF, 5'd5);
        t_exp[6] = mk(32'h8000_0000, 1'b1, 32'd5, 32'd0, 5'd6);
        t_exp[7] = mk(32'h8000_0000, 1'b1, 32'd4, 32'd0, 5'd7);
        t_exp[8] = mk(32'h0000_0001, 1'b0, 32'd0, 32'd0, 5'd8);
        t_exp[9] = mk(32'hFFFF_FFFD, 1'b0, 32'd0, 32'd1, 5'd10);

        bus.start_valid = 1'b0; bus.op = '0; bus.operand_a = '0; bus.operand_b = '0;
        bus.tag_in = '0; bus.flush = 1'b0; bus.res_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_start_ready", bus.start_ready, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_res_exc", bus.res_exc, 0);
        check("rst_res_data", bus.res_data, 0);
        check("rst_res_tag", bus.res_tag, 0);
        check("rst_res_code", bus.res_code, 0);
`ifdef MDU_REM_EN
        check("rst_res_rem", bus.res_rem, 0);
`endif
        rst = 1'b0;
        #1;
        check("ready_after_rst", bus.start_ready, 1);
        @(negedge clk);

        // Directed arithmetic cases
        for (int i = 0; i < 10; i++) begin
            issue(t_op[i], t_a[i], t_b[i], t_exp[i].tag);
            collect(t_exp[i]);
            consume();
        end

        // Back-pressure: hold 10 cycles, then take result and accept 3x4 in the same cycle
        issue(2'd0, 32'd6, 32'd7, 5'd3);
        collect(mk(32'd42, 1'b0, 32'd0, 32'd0, 5'd3));
        for (int i = 0; i < 10; i++) begin
            check("hold_valid", bus.res_valid, 1);
            check("hold_data", bus.res_data, 42);
            check("hold_tag", bus.res_tag, 3);
            check("hold_start_ready", bus.start_ready, 0);
            @(negedge clk);
        end
        bus.res_ready = 1'b1;
        bus.start_valid = 1'b1;
        bus.op = 2'd0; bus.operand_a = 32'd3; bus.operand_b = 32'd4; bus.tag_in = 5'd4;
        #1;
        check("b2b_start_ready", bus.start_ready, 1);
        @(negedge clk);
        bus.res_ready = 1'b0;
        bus.start_valid = 1'b0;
        bus.operand_a = $urandom; bus.operand_b = $urandom;
        check("b2b_busy", bus.busy, 1);
        collect(mk(32'd12, 1'b0, 32'd0, 32'd0, 5'd4));
        consume();

        // Flush at the 10th RUN cycle
        issue(2'd0, 32'd123, 32'd456, 5'd7);
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_start_ready", bus.start_ready, 1);
        check("flush_busy", bus.busy, 0);
        hits = 0;
        repeat (40) begin
            if (bus.res_valid === 1'b1) hits++;
            @(negedge clk);
        end
        check("flush_no_result", hits, 0);
        issue(2'd0, 32'd3, 32'd4, 5'd2);
        collect(mk(32'd12, 1'b0, 32'd0, 32'd0, 5'd2));
        consume();

        // Flush together with accept drops the op
        bus.start_valid = 1'b1; bus.flush = 1'b1;
        bus.op = 2'd0; bus.operand_a = 32'd9; bus.operand_b = 32'd9; bus.tag_in = 5'd1;
        @(negedge clk);
        bus.start_valid = 1'b0; bus.flush = 1'b0;
        check("flush_accept_busy", bus.busy, 0);
        hits = 0;
        repeat (40) begin
            if (bus.res_valid === 1'b1) hits++;
            @(negedge clk);
        end
        check("flush_accept_no_result", hits, 0);

        // Flush in DONE with res_ready
        issue(2'd0, 32'd2, 32'd5, 5'd6);
        collect(mk(32'd10, 1'b0, 32'd0, 32'd0, 5'd6));
        bus.res_ready = 1'b1; bus.flush = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0; bus.flush = 1'b0;
        check("flush_done_valid", bus.res_valid, 0);
        check("flush_done_busy", bus.busy, 0);

        // Reset at the 5th RUN cycle of a divide
        issue(2'd1, 32'd1000, 32'd7, 5'd11);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", bus.res_valid, 0);
        check("midrst_busy", bus.busy, 0);
        rst = 1'b0;
        #1;
        check("midrst_ready", bus.start_ready, 1);
        @(negedge clk);
        issue(2'd1, 32'd1000, 32'd7, 5'd11);
        collect(mk(32'd142, 1'b0, 32'd0, 32'd6, 5'd11));
        consume();

        // Random ops against the reference model, random consumer delay
        for (int i = 0; i < 30; i++) begin
            rop  = 2'($urandom_range(0, 3));
            ra   = pick();
            rb   = pick();
            rtag = 5'($urandom);
            issue(rop, ra, rb, rtag);
            collect(model(rop, ra, rb, rtag));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            check("rand_hold_ready", bus.start_ready, 0);
            consume();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
